uart_cmd_parser: RTL
====================

# uart_cmd_parser

Command decoder directly downstream of `uart_rx`. It consumes the received byte stream (`rx_data` / `rx_done`) and parses short ASCII command lines. It issues single-cycle start/setting pulses and a threshold-load strobe toward `Controller`, alongside the debounced push-button pulses. Malformed lines are discarded and reported with an error pulse and code.

## Interface
- `TIMEOUT_CYC`, default 50_000_000: inter-byte timeout in `clk` cycles (1 s at 50 MHz). Used only with `CMD_TIMEOUT_EN`.
- `TO_BIT`, default 26: width of the timeout counter. Must hold `TIMEOUT_CYC-1`.
- `THR_RESET`, default 8'd30: reset value of `thr_val`.

Ports:
- `clk`  in  1  system clock. Single clock domain.
- `n_rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  received byte. Valid in the cycle `rx_done`=1.
- `rx_done`  in  1  one-cycle byte-valid pulse from `uart_rx`.
- `cmd_start`  out  1  one-cycle pulse on a valid "S" line.
- `cmd_setting`  out  1  one-cycle pulse on a valid "M" line.
- `thr_val`  out  8  last accepted threshold. Held between loads.
- `thr_load`  out  1  one-cycle pulse. `thr_val` is updated in the same cycle.
- `err`  out  1  one-cycle pulse on a rejected line.
- `err_code`  out  2  valid with `err`. Held until the next `err`.
  - 1 = syntax
  - 2 = range
  - 3 = timeout
- `busy`  out  1  high while the FSM is not in IDLE.

## Operation
- Terminator (TERM) is CR 0x0D or LF 0x0A. Commands are uppercase only.
- Accepted lines:
  - "S" TERM: pulse `cmd_start`.
  - "M" TERM: pulse `cmd_setting`.
  - "T" d{1..3} TERM: load the decimal value 0..255 into `thr_val`.
- FSM states: IDLE, GOT_S, GOT_M, GOT_T, DIGITS, FLUSH.
- Transitions occur only on `rx_done`, except timeout.
- From IDLE:
  - 'S' goes to GOT_S; 'M' goes to GOT_M; 'T' goes to GOT_T.
  - TERM stays in IDLE with no output. Empty lines, including CR LF pairs, are ignored.
  - Any other byte goes to FLUSH with code 1.
- From GOT_S or GOT_M:
  - TERM issues the pulse and returns to IDLE.
  - Any other byte goes to FLUSH with code 1.
- From GOT_T:
  - A digit '0'..'9' sets `acc`=digit, `cnt`=1, and goes to DIGITS.
  - TERM issues `err` code 1 and returns to IDLE.
  - Any other byte goes to FLUSH with code 1.
- From DIGITS:
  - A digit sets `acc` = `acc`*10 + digit. `acc` is 10 bits wide; `acc`*10 is formed as (`acc`<<3)+(`acc`<<1).
  - If `cnt`==3 already, or the new `acc` > 255, go to FLUSH with code 2.
  - TERM loads `thr_val` = `acc`[7:0], pulses `thr_load`, and returns to IDLE.
  - Any other byte goes to FLUSH with code 1.
- FLUSH:
  - Discards bytes until TERM.
  - On TERM, pulses `err` with the latched code and returns to IDLE.
  - Only the first error in a line is reported, exactly once.
- Leading zeros count toward the 3-digit limit: "T007" is accepted and "T0007" is rejected with code 2.

## Timing
- Reset values of outputs:
  - `cmd_start`, `cmd_setting`, `thr_load`, `err` = 0.
  - `err_code` = 0.
  - `busy` = 0.
  - `thr_val` = `THR_RESET`.
- Internal reset values: FSM = IDLE, `acc` = 0, `cnt` = 0, timeout counter = 0.
- All outputs are registered.
- Latency: every pulse is high for exactly one cycle, the cycle after the `rx_done` that carried the TERM.
- No backpressure. One byte can be accepted per cycle, so back-to-back `rx_done` is legal.
- Asserting `n_rst` mid-line discards the partial command immediately. No pulse is issued.
- At most one of `cmd_start`, `cmd_setting`, `thr_load`, `err` is high in any cycle.

## Configuration
- Macro `CMD_TIMEOUT_EN`.
- Defined:
  - The counter clears on every `rx_done` and while in IDLE, and otherwise increments.
  - When the counter reaches `TIMEOUT_CYC-1` in a non-IDLE state, the FSM returns to IDLE and pulses `err` with code 3 on the next cycle. Any pending FLUSH code is overridden.
  - If `rx_done` arrives in the expiry cycle, the byte takes precedence: it is processed normally, the counter clears, and no timeout occurs.
- Undefined: no counter logic. A partial line waits indefinitely, and code 3 is never produced. `TIMEOUT_CYC` and `TO_BIT` are ignored.

## Test plan
- Reset, then "S",0x0D: `cmd_start`=1 for one cycle, one cycle after the CR `rx_done`. `thr_val`=30 throughout.
- "T128",0x0A: `thr_load` pulse, `thr_val`=128. Then "T0" CR: `thr_val`=0.
- "T256" CR, then "T1234" CR: two `err` pulses, both code 2, with `thr_val` unchanged. Then "M" CR LF: one `cmd_setting` pulse and no error for the LF.
- "X" CR, "SS" CR, "T" CR, "T1A" CR: four `err` pulses, each code 1. No command pulses.
- With `CMD_TIMEOUT_EN` and `TIMEOUT_CYC`=10: send "T1", then idle. Required response: `err` code 3 and `busy`=0 ten cycles after the last `rx_done`. A following "S" CR yields `cmd_start`.
- Send "T12", assert `n_rst` mid-line, release, then send "3" CR. Required response: `err` code 1, `thr_val`=30, no `thr_load`.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// ASCII command-line decoder behind uart_rx: S, M and T<0..255> lines.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN.
module uart_cmd_parser #(
  parameter int unsigned TIMEOUT_CYC = 50_000_000,
  parameter int unsigned TO_BIT      = 26,
  parameter logic [7:0]  THR_RESET   = 8'd30
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_start,
  output logic       cmd_setting,
  output logic [7:0] thr_val,
  output logic       thr_load,
  output logic       err,
  output logic [1:0] err_code,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, GOT_S, GOT_M, GOT_T, DIGITS, FLUSH
  } state_t;

  state_t     state;
  logic [9:0] acc;
  logic [1:0] cnt;
  logic [1:0] fl_code;
  logic       is_term;
  logic       is_dig;
  logic [9:0] acc_nxt;
  logic       expire;

  assign is_term = (rx_data == 8'h0D) || (rx_data == 8'h0A);
  assign is_dig  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign acc_nxt = (acc << 3) + (acc << 1) + {6'd0, rx_data[3:0]};

`ifdef CMD_TIMEOUT_EN
  logic [TO_BIT-1:0] to_cnt;

  assign expire = (state != IDLE) && !rx_done
               && (to_cnt == TO_BIT'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      to_cnt <= '0;
    end else if (rx_done || state == IDLE || expire) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYC == TO_BIT);
  assign expire     = 1'b0;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      fl_code     <= '0;
      cmd_start   <= 1'b0;
      cmd_setting <= 1'b0;
      thr_load    <= 1'b0;
      err         <= 1'b0;
      err_code    <= '0;
      thr_val     <= THR_RESET;
      busy        <= 1'b0;
    end else begin
      cmd_start   <= 1'b0;
      cmd_setting <= 1'b0;
      thr_load    <= 1'b0;
      err         <= 1'b0;
      if (rx_done) begin
        unique case (state)
          IDLE: begin
            if (rx_data == "S") begin
              state <= GOT_S;
              busy  <= 1'b1;
            end else if (rx_data == "M") begin
              state <= GOT_M;
              busy  <= 1'b1;
            end else if (rx_data == "T") begin
              state <= GOT_T;
              busy  <= 1'b1;
            end else if (!is_term) begin
              state   <= FLUSH;
              busy    <= 1'b1;
              fl_code <= 2'd1;
            end
          end
          GOT_S, GOT_M: begin
            if (is_term) begin
              cmd_start   <= (state == GOT_S);
              cmd_setting <= (state == GOT_M);
              state       <= IDLE;
              busy        <= 1'b0;
            end else begin
              state   <= FLUSH;
              fl_code <= 2'd1;
            end
          end
          GOT_T: begin
            if (is_dig) begin
              acc   <= {6'd0, rx_data[3:0]};
              cnt   <= 2'd1;
              state <= DIGITS;
            end else if (is_term) begin
              err      <= 1'b1;
              err_code <= 2'd1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              state   <= FLUSH;
              fl_code <= 2'd1;
            end
          end
          DIGITS: begin
            if (is_dig) begin
              if (cnt == 2'd3 || acc_nxt > 10'd255) begin
                state   <= FLUSH;
                fl_code <= 2'd2;
              end else begin
                acc <= acc_nxt;
                cnt <= cnt + 2'd1;
              end
            end else if (is_term) begin
              thr_val  <= acc[7:0];
              thr_load <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end else begin
              state   <= FLUSH;
              fl_code <= 2'd1;
            end
          end
          FLUSH: begin
            if (is_term) begin
              err      <= 1'b1;
              err_code <= fl_code;
              state    <= IDLE;
              busy     <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (expire) begin
        // a stalled line is dropped; the timeout outranks any flush code
        err      <= 1'b1;
        err_code <= 2'd3;
        state    <= IDLE;
        busy     <= 1'b0;
      end
    end
  end

endmodule
